// File: rtl/video_pos_tracker.sv
// Tracks the pixel position in a DE-framed video stream, measures the active line width
// and frame height, and declares lock once the timing matches H_ACT x V_ACT.
module video_pos_tracker #(
  parameter int H_ACT       = 1920,
  parameter int V_ACT       = 1080,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [23:0] i_vid_data,
  input  logic        i_vid_hsync,
  input  logic        i_vid_vsync,
  input  logic        i_vid_VDE,
  output logic [23:0] o_vid_data,
  output logic        o_vid_hsync,
  output logic        o_vid_vsync,
  output logic        o_vid_VDE,
  output logic [11:0] o_hcount,
  output logic [11:0] o_vcount,
  output logic        o_frame_start,
  output logic [11:0] o_line_width,
  output logic [11:0] o_frame_height,
  output logic        o_locked,
  output logic        o_err
);

  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_ACQUIRE  = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;

  localparam logic [11:0] H_ACT_C  = 12'(H_ACT);
  localparam logic [11:0] V_ACT_C  = 12'(V_ACT);
  localparam logic [7:0]  LOCK_C   = 8'(LOCK_FRAMES);
  localparam logic [11:0] CNT_MAX  = 12'hFFF;

  logic        vsync_prev_q, vde_prev_q;
  logic [11:0] pix_cnt_q, pix_cnt_d;
  logic [11:0] line_cnt_q, line_cnt_d;
  logic        fs_pend_q, fs_pend_d;
  logic        frame_bad_q, frame_bad_d;
  logic [1:0]  state_q, state_d;
  logic [7:0]  match_q, match_d;
  logic        err_q, err_d;

  logic [23:0] data_q;
  logic        hsync_q, vsync_q, vde_q;
  logic [11:0] hcount_q, hcount_d;
  logic [11:0] vcount_q, vcount_d;
  logic        fs_q, fs_d;
  logic [11:0] width_q, width_d;
  logic [11:0] height_q, height_d;

  logic        line_end, vs_edge, line_bad, frame_good;
  logic [11:0] lines_done;

  // NOTE: every signal assigned here gets a default first so no latch can be inferred.
  always_comb begin
    line_end   = vde_prev_q & ~i_vid_VDE;
    vs_edge    = i_vid_vsync & ~vsync_prev_q;
    // A line ending in the same cycle as the vsync edge still belongs to the old frame.
    lines_done = line_cnt_q;
    if (line_end && line_cnt_q != CNT_MAX) lines_done = line_cnt_q + 12'd1;
    line_bad   = line_end && (pix_cnt_q != H_ACT_C);
    frame_good = !frame_bad_q && !line_bad && (lines_done == V_ACT_C);

    pix_cnt_d = pix_cnt_q;
    if (i_vid_VDE) begin
      if (pix_cnt_q != CNT_MAX) pix_cnt_d = pix_cnt_q + 12'd1;
    end else if (line_end) begin
      pix_cnt_d = 12'd0;
    end
    line_cnt_d  = vs_edge ? 12'd0 : lines_done;

    hcount_d    = i_vid_VDE ? pix_cnt_q  : 12'd0;
    vcount_d    = i_vid_VDE ? line_cnt_q : 12'd0;
    fs_d        = i_vid_VDE & fs_pend_q;
    fs_pend_d   = vs_edge ? 1'b1 : (i_vid_VDE ? 1'b0 : fs_pend_q);
    width_d     = line_end ? pix_cnt_q : width_q;
    height_d    = vs_edge ? lines_done : height_q;
    frame_bad_d = vs_edge ? 1'b0 : (frame_bad_q | line_bad);

    state_d = state_q;
    match_d = match_q;
    err_d   = 1'b0;
    case (state_q)
      ST_UNLOCKED: begin
        if (vs_edge) begin
          state_d = ST_ACQUIRE;
          match_d = 8'd0;
        end
      end
      ST_ACQUIRE: begin
        if (vs_edge) begin
          if (frame_good) begin
            match_d = match_q + 8'd1;
            if (match_d >= LOCK_C) state_d = ST_LOCKED;
          end else begin
            match_d = 8'd0;
          end
        end
      end
      ST_LOCKED: begin
        if (line_bad || (vs_edge && lines_done != V_ACT_C)) begin
          err_d   = 1'b1;
          state_d = ST_UNLOCKED;
          match_d = 8'd0;
        end
      end
      default: begin
        state_d = ST_UNLOCKED;
        match_d = 8'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vsync_prev_q <= 1'b0;
      vde_prev_q   <= 1'b0;
      pix_cnt_q    <= 12'd0;
      line_cnt_q   <= 12'd0;
      fs_pend_q    <= 1'b0;
      frame_bad_q  <= 1'b0;
      state_q      <= ST_UNLOCKED;
      match_q      <= 8'd0;
      err_q        <= 1'b0;
      data_q       <= 24'd0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      vde_q        <= 1'b0;
      hcount_q     <= 12'd0;
      vcount_q     <= 12'd0;
      fs_q         <= 1'b0;
      width_q      <= 12'd0;
      height_q     <= 12'd0;
    end else begin
      vsync_prev_q <= i_vid_vsync;
      vde_prev_q   <= i_vid_VDE;
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      fs_pend_q    <= fs_pend_d;
      frame_bad_q  <= frame_bad_d;
      state_q      <= state_d;
      match_q      <= match_d;
      err_q        <= err_d;
      data_q       <= i_vid_data;
      hsync_q      <= i_vid_hsync;
      vsync_q      <= i_vid_vsync;
      vde_q        <= i_vid_VDE;
      hcount_q     <= hcount_d;
      vcount_q     <= vcount_d;
      fs_q         <= fs_d;
      width_q      <= width_d;
      height_q     <= height_d;
    end
  end

  assign o_vid_data     = data_q;
  assign o_vid_hsync    = hsync_q;
  assign o_vid_vsync    = vsync_q;
  assign o_vid_VDE      = vde_q;
  assign o_hcount       = hcount_q;
  assign o_vcount       = vcount_q;
  assign o_frame_start  = fs_q;
  assign o_line_width   = width_q;
  assign o_frame_height = height_q;
  assign o_locked       = (state_q == ST_LOCKED);
  assign o_err          = err_q;

endmodule

// File: tb/tb_video_pos_tracker.sv
// Randomized bench for video_pos_tracker: a frame-level reference model fills a scoreboard
// queue as stimulus is driven; an independent monitor compares every output cycle.
module tb_video_pos_tracker;

  localparam int H = 6;
  localparam int V = 4;
  localparam int L = 2;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic [23:0] vid_data = '0;
  logic        hs = 1'b0, vs = 1'b0, vde = 1'b0;
  logic [23:0] o_vid_data;
  logic        o_vid_hsync, o_vid_vsync, o_vid_VDE;
  logic [11:0] o_hcount, o_vcount, o_line_width, o_frame_height;
  logic        o_frame_start, o_locked, o_err;

  always #5 clk = ~clk;

  video_pos_tracker #(.H_ACT(H), .V_ACT(V), .LOCK_FRAMES(L)) dut (
    .clk(clk), .n_rst(n_rst),
    .i_vid_data(vid_data), .i_vid_hsync(hs), .i_vid_vsync(vs), .i_vid_VDE(vde),
    .o_vid_data(o_vid_data), .o_vid_hsync(o_vid_hsync), .o_vid_vsync(o_vid_vsync),
    .o_vid_VDE(o_vid_VDE), .o_hcount(o_hcount), .o_vcount(o_vcount),
    .o_frame_start(o_frame_start), .o_line_width(o_line_width),
    .o_frame_height(o_frame_height), .o_locked(o_locked), .o_err(o_err)
  );

  typedef struct {
    logic [23:0] data;
    logic        hs, vs, vde;
    int          hcount, vcount;
    logic        fs;
    int          lw, fh;
    logic        locked, err;
    int          tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  bit   rel_pend = 0;

  // Reference model: frame described as the list of completed line widths since vsync.
  bit   m_pvs, m_pvde, m_fspend;
  int   m_cur, m_lw, m_fh, m_mode, m_streak;
  int   m_widths[$];

  always @(posedge clk) edge_cnt++;

  function automatic int sat(input int x);
    return (x > 4095) ? 4095 : x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic model_reset();
    m_pvs = 0; m_pvde = 0; m_fspend = 0;
    m_cur = 0; m_lw = 0; m_fh = 0; m_mode = 0; m_streak = 0;
    m_widths.delete();
  endtask

  task automatic model_step(input logic s_vs, input logic s_hs, input logic s_vde,
                            input logic [23:0] d, output exp_t e);
    bit le, ve, ok, bad_line;
    le = m_pvde && !s_vde;
    ve = s_vs && !m_pvs;
    e.data = d; e.hs = s_hs; e.vs = s_vs; e.vde = s_vde;
    e.hcount = s_vde ? sat(m_cur) : 0;
    e.vcount = s_vde ? sat(m_widths.size()) : 0;
    e.fs = s_vde && m_fspend;
    e.err = 0;
    bad_line = 0;
    if (le) begin
      m_widths.push_back(m_cur);
      m_lw = sat(m_cur);
      bad_line = (m_cur != H);
    end
    ok = (m_widths.size() == V);
    foreach (m_widths[i]) if (m_widths[i] != H) ok = 0;
    if (ve) m_fh = sat(m_widths.size());
    case (m_mode)
      0: if (ve) begin m_mode = 1; m_streak = 0; end
      1: if (ve) begin
           if (ok) begin
             m_streak++;
             if (m_streak >= L) m_mode = 2;
           end else m_streak = 0;
         end
      default: if (bad_line || (ve && m_widths.size() != V)) begin
                 e.err = 1; m_mode = 0; m_streak = 0;
               end
    endcase
    e.lw = m_lw; e.fh = m_fh; e.locked = (m_mode == 2);
    if (ve) m_widths.delete();
    if (s_vde) m_cur++;
    else if (le) m_cur = 0;
    if (ve) m_fspend = 1;
    else if (s_vde) m_fspend = 0;
    m_pvs = s_vs; m_pvde = s_vde;
  endtask

  // One pixel-clock of stimulus; the expected response lands in the scoreboard.
  task automatic cyc(input logic s_vs, input logic s_hs, input logic s_vde);
    exp_t e;
    logic [23:0] d;
    @(posedge clk); #1;
    if (rel_pend) begin n_rst = 1'b1; rel_pend = 0; end
    d = 24'($urandom);
    vid_data = d; vs = s_vs; hs = s_hs; vde = s_vde;
    model_step(s_vs, s_hs, s_vde, d, e);
    e.tag = edge_cnt + 1;
    sb.push_back(e);
  endtask

  task automatic line(input int w, input int blank);
    for (int i = 0; i < w; i++) cyc(0, 0, 1);
    for (int i = 0; i < blank; i++) cyc(0, i == 1, 0);
  endtask

  task automatic vsync_pulse(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0);
    cyc(0, 0, 0);
  endtask

  task automatic frame();
    vsync_pulse(2);
    for (int i = 0; i < V; i++) line(H, 3);
  endtask

  task automatic check_all_zero(input string tagname);
    check({tagname, "_data"}, {8'd0, o_vid_data}, 0);
    check({tagname, "_pos"}, {8'd0, o_hcount, o_vcount}, 0);
    check({tagname, "_meas"}, {8'd0, o_line_width, o_frame_height}, 0);
    check({tagname, "_flags"}, {26'd0, o_vid_hsync, o_vid_vsync, o_vid_VDE,
                                o_frame_start, o_locked, o_err}, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    n_rst = 1'b0;
    sb.delete();
    model_reset();
    #1;
    check_all_zero("rst_async");
    repeat (3) @(posedge clk);
    rel_pend = 1;
  endtask

  // Monitor: compares every output cycle against the oldest matching scoreboard entry.
  initial begin
    exp_t e;
    logic [77:0] act, expv;
    forever begin
      @(posedge clk); #2;
      while (sb.size() > 0 && sb[0].tag <= edge_cnt) begin
        e = sb.pop_front();
        if (e.tag == edge_cnt) begin
          act  = {o_vid_data, o_vid_hsync, o_vid_vsync, o_vid_VDE, o_hcount, o_vcount,
                  o_frame_start, o_line_width, o_frame_height, o_locked, o_err};
          expv = {e.data, e.hs, e.vs, e.vde, 12'(e.hcount), 12'(e.vcount),
                  e.fs, 12'(e.lw), 12'(e.fh), e.locked, e.err};
          checks++;
          if (act !== expv) begin
            errors++;
            $display("FAIL outputs cycle %0d: got hc=%0d vc=%0d fs=%b lw=%0d fh=%0d lk=%b er=%b vde=%b (%h) expected hc=%0d vc=%0d fs=%b lw=%0d fh=%0d lk=%b er=%b vde=%b (%h)",
                     edge_cnt, o_hcount, o_vcount, o_frame_start, o_line_width, o_frame_height,
                     o_locked, o_err, o_vid_VDE, act, e.hcount, e.vcount, e.fs, e.lw, e.fh,
                     e.locked, e.err, e.vde, expv);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int nl, w;
    model_reset();
    #3 n_rst = 1'b0;
    #1 check_all_zero("rst_init");
    repeat (2) @(posedge clk);
    rel_pend = 1;
    repeat (3) cyc(0, 0, 0);

    // Lock acquisition: ACQUIRE on the first edge, two good frames, lock on the third edge.
    frame();
    frame();
    check("locked_before_edge3", {31'd0, o_locked}, 0);
    vsync_pulse(2);
    check("locked_at_edge3", {31'd0, o_locked}, 1);
    line(H, 3);

    // Short line while locked: one-cycle error pulse after the line end, lock lost.
    for (int i = 0; i < H - 1; i++) cyc(0, 0, 1);
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    check("err_pulse", {31'd0, o_err}, 1);
    check("short_width", {20'd0, o_line_width}, H - 1);
    cyc(0, 0, 0);
    check("err_one_cycle", {31'd0, o_err}, 0);
    check("unlocked_after_err", {31'd0, o_locked}, 0);
    line(H, 3);
    line(H, 3);

    frame();
    frame();
    frame();
    check("relocked", {31'd0, o_locked}, 1);

    // Last line of a frame ends in the same cycle as the next vsync rise.
    vsync_pulse(2);
    for (int i = 0; i < V - 1; i++) line(H, 3);
    for (int i = 0; i < H; i++) cyc(0, 0, 1);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    check("height_same_cycle", {20'd0, o_frame_height}, V);
    check("locked_same_cycle", {31'd0, o_locked}, 1);
    cyc(0, 0, 0);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    check("vcount_after_sync", {20'd0, o_vcount}, 0);
    check("frame_start_first", {31'd0, o_frame_start}, 1);
    cyc(0, 0, 1);
    check("frame_start_once", {31'd0, o_frame_start}, 0);
    for (int i = 0; i < H - 3; i++) cyc(0, 0, 1);
    cyc(0, 0, 0); cyc(0, 0, 0);
    for (int i = 0; i < V - 1; i++) line(H, 3);

    // Randomized frames with occasional timing faults and coincident sync/line-end.
    for (int f = 0; f < 30; f++) begin
      vsync_pulse(1 + $urandom_range(0, 1));
      nl = ($urandom_range(0, 3) == 0) ? V - 1 + $urandom_range(0, 2) : V;
      for (int l = 0; l < nl; l++) begin
        w = ($urandom_range(0, 7) == 0) ? H - 1 + $urandom_range(0, 2) : H;
        if (l == nl - 1 && $urandom_range(0, 2) == 0) begin
          for (int i = 0; i < w; i++) cyc(0, 0, 1);
          cyc(1, 0, 0);
        end else begin
          line(w, 2 + $urandom_range(0, 2));
        end
      end
    end

    // Overlong line: pixel count and width saturate at 4095.
    vsync_pulse(2);
    line(4100, 3);
    check("width_saturated", {20'd0, o_line_width}, 4095);

    frame();
    frame();
    frame();
    check("locked_before_reset", {31'd0, o_locked}, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1);
    do_reset();
    for (int i = 0; i < 2; i++) cyc(0, 0, 1);
    cyc(0, 0, 0); cyc(0, 0, 0);
    line(H, 3);
    frame();
    frame();
    check("no_lock_after_2_edges", {31'd0, o_locked}, 0);
    vsync_pulse(2);
    check("lock_after_3_edges", {31'd0, o_locked}, 1);
    line(H, 3);
    repeat (4) cyc(0, 0, 0);
    repeat (3) @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
